seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 100000: clock cycles per digit slot; legal range 2..2^20.
REQ-003 Parameter BLANK_CYCLES, default 1000: anodes-off cycles at the start of each slot (anti-ghosting); SHALL satisfy BLANK_CYCLES < CLK_DIV.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means AN, CA and DP drive 0 to light; 0 means they drive 1 to light.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 seg_in  input  7*NUM_DIGITS  segment patterns, 1 = lit; digit d uses bits [7d+6:7d], digit 0 rightmost.
REQ-008 dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 digit_en  input  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-010 load  input  1  single-cycle strobe that captures seg_in, dp_in and digit_en.
REQ-011 AN  output  NUM_DIGITS  anode drive, at most one active.
REQ-012 CA  output  7  cathode drive for segments a..g (bit 0 = a).
REQ-013 DP  output  1  decimal point drive.
REQ-014 frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-015 pending  output  1  high while captured data waits for the next frame boundary.

Function
REQ-016 Prescaler pcnt SHALL count 0..CLK_DIV-1 and wrap to 0; tick is asserted when pcnt == CLK_DIV-1.
REQ-017 Digit index idx SHALL increment on tick and wrap from NUM_DIGITS-1 to 0; it holds otherwise.
REQ-018 Frame boundary = tick while idx == NUM_DIGITS-1.
REQ-019 load SHALL write seg_in, dp_in and digit_en into shadow registers and set pending.
REQ-020 At a frame boundary with pending set, shadow SHALL copy to display registers and pending SHALL clear.
REQ-021 load coinciding with a frame boundary: display registers SHALL take the current inputs directly; shadow also captures them; pending ends the cycle low.
REQ-022 load with no boundary while pending is already set: shadow is overwritten (last load wins).
REQ-023 Blank window = pcnt < BLANK_CYCLES: all AN inactive, CA all inactive, DP inactive.
REQ-024 Outside the blank window, AN[idx] is active only if display digit_en[idx] = 1, with CA = display seg[idx] and DP = display dp[idx], each mapped through ACTIVE_LOW polarity.
REQ-025 A disabled digit SHALL drive AN, CA and DP all inactive for its whole slot.
REQ-026 AN, CA, DP and frame_done SHALL be registered: they reflect internal state (pcnt, idx, display registers) with exactly one clock of latency.
REQ-027 frame_done SHALL be high for exactly the one cycle after each boundary cycle.
REQ-028 NUM_DIGITS = 1: idx stays 0 and every tick is a frame boundary.

Reset
REQ-029 While rst_n = 0: pcnt = 0, idx = 0, pending = 0, shadow and display registers all 0, frame_done = 0, and AN, CA, DP inactive per ACTIVE_LOW.
REQ-030 Reset asserted mid-frame or mid-load SHALL take effect immediately and discard shadow contents.
REQ-031 Scanning SHALL resume at pcnt = 0, idx = 0 on the first rising clk edge after rst_n deasserts.

Structure
REQ-032 Shared package seg_pkg SHALL hold the segment-width constant (7), the MAX_DIGITS limit (8) and the helper for counter width (clog2).
REQ-033 The prescaler and tick generator SHALL be a sub-module, scan_tick_gen (parameter CLK_DIV; ports clk, rst_n, tick).
REQ-034 All counter widths SHALL be derived from parameters; there SHALL be no hard-coded 4-digit logic.

Verification (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-035 Reset release, load seg_in = {7'h06,7'h5B,7'h4F,7'h66}, digit_en = 4'hF -> after the next boundary, AN cycles 1110,1101,1011,0111 for 6 cycles each, separated by 2 cycles of 1111; CA = ~pattern of the selected digit.
REQ-036 digit_en = 4'b1011 -> AN stays 1111 throughout digit 2's slot; the other three digits are unchanged.
REQ-037 load mid-frame -> pending = 1 and the display keeps the old data until the boundary; then the new data appears from digit 0 and pending = 0.
REQ-038 load on the boundary cycle -> new data shown starting at digit 0 of the next frame; pending stays 0.
REQ-039 Two loads in one frame (A, then B) -> only B is displayed; A is never visible.
REQ-040 rst_n pulled low during digit 2 -> AN = 1111, CA = 7'h7F, DP = 1 immediately; the scan restarts at digit 0 and the display stays blank until the next load.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and width helpers for the multiplexed seven-segment scan driver.
package seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed for a counter spanning 0..v-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/seg_scan_driver_tick.sv
// scan_tick_gen: free-running prescaler 0..CLK_DIV-1 with a tick on the last count.
module scan_tick_gen
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned    PW   = cnt_w(CLK_DIV);
  localparam logic [PW-1:0]  TERM = PW'(CLK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = (pcnt_q == TERM);

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadow/display double buffering,
// per-slot anti-ghost blanking and registered AN/CA/DP outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SEG_W*NUM_DIGITS-1:0]   seg_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          load,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic [SEG_W-1:0]              CA,
  output logic                          DP,
  output logic                          frame_done,
  output logic                          pending
);

  localparam int unsigned   IW       = cnt_w(NUM_DIGITS);
  localparam int unsigned   BW       = cnt_w(BLANK_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLANK_V  = BW'(BLANK_CYCLES);
  localparam logic          POL      = (ACTIVE_LOW != 0);

  logic tick, boundary, blank, lit;

  logic [IW-1:0]               idx_q, idx_d;
  logic [BW-1:0]               bcnt_q, bcnt_d;
  logic                        pending_q, pending_d;
  logic [SEG_W*NUM_DIGITS-1:0] sh_seg_q, sh_seg_d, dsp_seg_q, dsp_seg_d;
  logic [NUM_DIGITS-1:0]       sh_dp_q, sh_dp_d, dsp_dp_q, dsp_dp_d;
  logic [NUM_DIGITS-1:0]       sh_en_q, sh_en_d, dsp_en_q, dsp_en_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [SEG_W-1:0]            ca_q, ca_d, seg_sel;
  logic                        dp_q, dp_d, fd_q;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign boundary = tick && (idx_q == LAST_IDX);

  // bcnt tracks min(pcnt, BLANK_CYCLES), so the blank window needs no prescaler tap.
  assign blank = (bcnt_q < BLANK_V);

  always_comb begin
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    if (tick) begin
      idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      bcnt_d = '0;
    end else if (blank) begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_comb begin
    sh_seg_d  = sh_seg_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    dsp_seg_d = dsp_seg_q;
    dsp_dp_d  = dsp_dp_q;
    dsp_en_d  = dsp_en_q;
    pending_d = pending_q;
    if (load) begin
      sh_seg_d  = seg_in;
      sh_dp_d   = dp_in;
      sh_en_d   = digit_en;
      pending_d = 1'b1;
    end
    // A load on the boundary bypasses the shadow so it is not delayed a frame.
    if (boundary) begin
      if (load) begin
        dsp_seg_d = seg_in;
        dsp_dp_d  = dp_in;
        dsp_en_d  = digit_en;
        pending_d = 1'b0;
      end else if (pending_q) begin
        dsp_seg_d = sh_seg_q;
        dsp_dp_d  = sh_dp_q;
        dsp_en_d  = sh_en_q;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    seg_sel = dsp_seg_q[idx_q*SEG_W +: SEG_W];
    lit     = !blank && dsp_en_q[idx_q];
    an_d    = (lit ? (NUM_DIGITS'(1) << idx_q) : '0) ^ {NUM_DIGITS{POL}};
    ca_d    = (lit ? seg_sel : '0) ^ {SEG_W{POL}};
    dp_d    = (lit && dsp_dp_q[idx_q]) ^ POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      bcnt_q    <= '0;
      pending_q <= 1'b0;
      sh_seg_q  <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      dsp_seg_q <= '0;
      dsp_dp_q  <= '0;
      dsp_en_q  <= '0;
      an_q      <= {NUM_DIGITS{POL}};
      ca_q      <= {SEG_W{POL}};
      dp_q      <= POL;
      fd_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      pending_q <= pending_d;
      sh_seg_q  <= sh_seg_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      dsp_seg_q <= dsp_seg_d;
      dsp_dp_q  <= dsp_dp_d;
      dsp_en_q  <= dsp_en_d;
      an_q      <= an_d;
      ca_q      <= ca_d;
      dp_q      <= dp_d;
      fd_q      <= boundary;
    end
  end

  assign AN         = an_q;
  assign CA         = ca_q;
  assign DP         = dp_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule
